tristate_bus_port: RTL and testbench

//  Parametrised, clocked bidirectional pad-bus controller. Extends a single-bit tristate

---
 rtl/tristate_bus_port.sv | 158 +++++++++++++++
 tb/tb_tristate_bus_port.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tristate_bus_port : clocked bidirectional pad-bus controller with        |
// | direction FSM, turnaround dead time, synchronised readback, write port.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tristate_bus_port #(
  parameter int               WIDTH       = 8,
  parameter int               TURN_CYCLES = 2,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir_req,
  output logic             tx_active,
  output logic             busy,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  input  logic [WIDTH-1:0] pad_in
);

  localparam int CNT_MAX = (TURN_CYCLES > SYNC_STAGES) ? TURN_CYCLES : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] SYNC_FULL = CNT_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TX_TURN = 2'd1,
    ST_TX      = 2'd2,
    ST_RX_TURN = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] turn_cnt_q,  turn_cnt_d;
  logic [CNT_W-1:0] fill_cnt_q,  fill_cnt_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] rd_data_q,   rd_data_d;
  logic             rd_valid_q,  rd_valid_d;
  logic [WIDTH-1:0] pad_out_q,   pad_out_d;
  logic             pad_oe_q,    pad_oe_d;
  logic             tx_active_q, tx_active_d;
  logic             busy_q,      busy_d;
  logic             wr_accept;

  // Direction FSM; TX_TURN may abort, RX_TURN always runs its full dead time.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      ST_RX: begin
        if (dir_req) begin
          state_d    = ST_TX_TURN;
          turn_cnt_d = TURN_LOAD;
        end
      end
      ST_TX_TURN: begin
        if (!dir_req) begin
          state_d = ST_RX;
        end else if (turn_cnt_q == '0) begin
          state_d = ST_TX;
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      ST_TX: begin
        if (!dir_req) begin
          state_d    = ST_RX_TURN;
          turn_cnt_d = TURN_LOAD;
        end
      end
      ST_RX_TURN: begin
        if (turn_cnt_q == '0) begin
          state_d = ST_RX;
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = ST_RX;
        turn_cnt_d = '0;
      end
    endcase
  end

  assign wr_ready  = (state_q == ST_TX) && dir_req;
  assign wr_accept = wr_valid && wr_ready;

  always_comb begin
    pad_out_d   = wr_accept ? wr_data : pad_out_q;
    pad_oe_d    = (state_d == ST_TX);
    tx_active_d = (state_d == ST_TX);
    busy_d      = (state_d == ST_TX_TURN) || (state_d == ST_RX_TURN);
  end

  // Readback: sync chain always shifts; rd_data samples its tail only while in RX.
  always_comb begin
    sync_d[0] = pad_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    rd_data_d = (state_q == ST_RX) ? sync_d[SYNC_STAGES-1] : rd_data_q;
    if (state_d != ST_RX || state_q != ST_RX) begin
      fill_cnt_d = '0;
    end else if (fill_cnt_q < SYNC_FULL) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end else begin
      fill_cnt_d = fill_cnt_q;
    end
    rd_valid_d = (state_d == ST_RX) && (fill_cnt_d == SYNC_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RX;
      turn_cnt_q  <= '0;
      fill_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      pad_out_q   <= RESET_OUT;
      pad_oe_q    <= 1'b0;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      turn_cnt_q  <= turn_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      pad_out_q   <= pad_out_d;
      pad_oe_q    <= pad_oe_d;
      tx_active_q <= tx_active_d;
      busy_q      <= busy_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign tx_active = tx_active_q;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign pad_out   = pad_out_q;
  assign pad_oe    = {WIDTH{pad_oe_q}};

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tristate_bus_port : vector table + scoreboard bench for two configs.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tristate_bus_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Config A: WIDTH=8, TURN_CYCLES=2, SYNC_STAGES=2, RESET_OUT=0
  logic       rst_n_a = 1'b0, dir_a = 1'b0, wv_a = 1'b0;
  logic [7:0] wd_a = '0, pin_a = 8'hA5;
  logic       tx_a, busy_a, wrr_a, rv_a;
  logic [7:0] rd_a, pout_a, poe_a;

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2), .RESET_OUT(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n_a), .dir_req(dir_a), .tx_active(tx_a), .busy(busy_a),
    .wr_data(wd_a), .wr_valid(wv_a), .wr_ready(wrr_a), .rd_data(rd_a), .rd_valid(rv_a),
    .pad_out(pout_a), .pad_oe(poe_a), .pad_in(pin_a));

  // Config B: WIDTH=16, TURN_CYCLES=0, RESET_OUT=BEEF
  logic        rst_n_b = 1'b0, dir_b = 1'b0, wv_b = 1'b0;
  logic [15:0] wd_b = '0, pin_b = 16'h0F0F;
  logic        tx_b, busy_b, wrr_b, rv_b;
  logic [15:0] rd_b, pout_b, poe_b;

  tristate_bus_port #(.WIDTH(16), .TURN_CYCLES(0), .SYNC_STAGES(2), .RESET_OUT(16'hBEEF)) u_b (
    .clk(clk), .rst_n(rst_n_b), .dir_req(dir_b), .tx_active(tx_b), .busy(busy_b),
    .wr_data(wd_b), .wr_valid(wv_b), .wr_ready(wrr_b), .rd_data(rd_b), .rd_valid(rv_b),
    .pad_out(pout_b), .pad_oe(poe_b), .pad_in(pin_b));

  typedef struct {
    logic       rst_n, dir, wv;
    logic [7:0] wd, pin;
    logic [7:0] e_oe, e_out, e_rd;
    logic       e_busy, e_tx, e_rv, e_wrr;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t cur;
  int   vidx = 0;
  int   low_cnt = 0;
  bit   seen_fall = 1'b0;
  logic prev_oe = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic d, input logic wv, input logic [7:0] wd,
                              input logic [7:0] pin, input logic [7:0] oe, input logic [7:0] out,
                              input logic [7:0] rd, input logic busy, input logic tx,
                              input logic rv, input logic wrr);
    vec_t v;
    v.rst_n = r; v.dir = d; v.wv = wv; v.wd = wd; v.pin = pin;
    v.e_oe = oe; v.e_out = out; v.e_rd = rd;
    v.e_busy = busy; v.e_tx = tx; v.e_rv = rv; v.e_wrr = wrr;
    return v;
  endfunction

  // Scoreboard consumer: outputs sampled 1 time unit after the edge they follow.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("a_pad_oe",    vidx, 32'(poe_a),  32'(cur.e_oe));
      chk("a_pad_out",   vidx, 32'(pout_a), 32'(cur.e_out));
      chk("a_rd_data",   vidx, 32'(rd_a),   32'(cur.e_rd));
      chk("a_busy",      vidx, 32'(busy_a), 32'(cur.e_busy));
      chk("a_tx_active", vidx, 32'(tx_a),   32'(cur.e_tx));
      chk("a_rd_valid",  vidx, 32'(rv_a),   32'(cur.e_rv));
      chk("a_wr_ready",  vidx, 32'(wrr_a),  32'(cur.e_wrr));
      if (poe_a == 8'h00) begin
        if (prev_oe) begin
          seen_fall = 1'b1;
          low_cnt   = 0;
        end
        low_cnt++;
      end else if (!prev_oe && seen_fall) begin
        chk("a_dead_time_gt_turn", vidx, 32'(low_cnt > 2), 32'd1);
      end
      prev_oe = poe_a[0];
      vidx++;
    end
  end

  task automatic step_b(input logic r, input logic d, input logic wv, input logic [15:0] wd);
    @(negedge clk);
    rst_n_b = r; dir_b = d; wv_b = wv; wd_b = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[31];

  initial begin
    //          rst dir wv  wd     pin    oe     out    rd     bsy tx rv wrr
    vt[0]  = mk(0, 0, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = mk(1, 0, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5, 0, 0, 1, 0);
    vt[5]  = vt[4];
    vt[6]  = mk(1, 1, 0, 8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5, 1, 0, 0, 0);
    vt[7]  = vt[6];
    vt[8]  = vt[6];
    vt[9]  = mk(1, 1, 1, 8'h3C, 8'hA5, 8'hFF, 8'h00, 8'hA5, 0, 1, 0, 1);
    vt[10] = mk(1, 1, 1, 8'h3C, 8'hA5, 8'hFF, 8'h3C, 8'hA5, 0, 1, 0, 1);
    vt[11] = mk(1, 1, 0, 8'h3C, 8'hA5, 8'hFF, 8'h3C, 8'hA5, 0, 1, 0, 1);
    vt[12] = mk(1, 0, 1, 8'h77, 8'hA5, 8'h00, 8'h3C, 8'hA5, 1, 0, 0, 0);
    vt[13] = mk(1, 0, 1, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'hA5, 1, 0, 0, 0);
    vt[14] = mk(1, 1, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'hA5, 1, 0, 0, 0);
    vt[15] = mk(1, 1, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'hA5, 0, 0, 0, 0);
    vt[16] = mk(1, 1, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 1, 0, 0, 0);
    vt[17] = vt[16];
    vt[18] = vt[16];
    vt[19] = mk(1, 1, 0, 8'h77, 8'h5A, 8'hFF, 8'h3C, 8'h5A, 0, 1, 0, 1);
    vt[20] = mk(1, 0, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 1, 0, 0, 0);
    vt[21] = vt[20];
    vt[22] = vt[20];
    vt[23] = mk(1, 0, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 0, 0, 0, 0);
    vt[24] = vt[23];
    vt[25] = mk(1, 0, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 0, 0, 1, 0);
    vt[26] = mk(1, 1, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 1, 0, 0, 0);
    vt[27] = mk(1, 0, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 0, 0, 0, 0);
    vt[28] = vt[27];
    vt[29] = mk(1, 0, 0, 8'h77, 8'h5A, 8'h00, 8'h3C, 8'h5A, 0, 0, 1, 0);
    vt[30] = vt[29];

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      rst_n_a = vt[i].rst_n; dir_a = vt[i].dir; wv_a = vt[i].wv;
      wd_a    = vt[i].wd;    pin_a = vt[i].pin;
      exp_q.push_back(vt[i]);
    end
    @(negedge clk);
    @(negedge clk);
    chk("a_scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);

    // Config B: zero turnaround and reset while driving.
    step_b(0, 0, 0, 16'h0000);
    step_b(0, 0, 0, 16'h0000);
    chk("b_rst_pad_oe",  0, 32'(poe_b),  32'h0000);
    chk("b_rst_pad_out", 0, 32'(pout_b), 32'hBEEF);
    chk("b_rst_tx",      0, 32'(tx_b),   32'd0);
    step_b(1, 0, 0, 16'h0000);
    chk("b_rx_busy",     1, 32'(busy_b), 32'd0);
    step_b(1, 1, 0, 16'h0000);
    chk("b_turn_busy",   2, 32'(busy_b), 32'd1);
    chk("b_turn_pad_oe", 2, 32'(poe_b),  32'h0000);
    step_b(1, 1, 0, 16'h0000);
    chk("b_tx_pad_oe",   3, 32'(poe_b),  32'hFFFF);
    chk("b_tx_active",   3, 32'(tx_b),   32'd1);
    chk("b_tx_wr_ready", 3, 32'(wrr_b),  32'd1);
    chk("b_tx_busy",     3, 32'(busy_b), 32'd0);
    step_b(1, 1, 1, 16'h1234);
    chk("b_write",       4, 32'(pout_b), 32'h1234);
    step_b(0, 1, 0, 16'h0000);
    chk("b_rst_tx_pad_oe",  5, 32'(poe_b),  32'h0000);
    chk("b_rst_tx_pad_out", 5, 32'(pout_b), 32'hBEEF);
    chk("b_rst_tx_active",  5, 32'(tx_b),   32'd0);
    chk("b_rst_tx_wrready", 5, 32'(wrr_b),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
